// File: rtl/wave_capture_pkg.sv
// rtl/wave_capture_pkg.sv - shared state encoding and record layout for wave_capture
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } cap_state_t;

    // Record layout, LSB first: value, ts, init, lost
    function automatic int rec_width(input int width, input int ts_width);
        return width + ts_width + 2;
    endfunction

    function automatic int init_bit(input int width, input int ts_width);
        return width + ts_width;
    endfunction

    function automatic int lost_bit(input int width, input int ts_width);
        return width + ts_width + 1;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - first-word-fall-through record FIFO with occupancy count
module capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Forced to zero while empty so stale entries never reach the outputs
    assign head  = empty ? '0 : mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - probe change recorder emitting timestamped records over a stream
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         probe,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [WIDTH-1:0]         out_value,
    output logic                     out_init,
    output logic                     out_lost,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int REC_W  = rec_width(WIDTH, TS_WIDTH);
    localparam int INIT_B = init_bit(WIDTH, TS_WIDTH);
    localparam int LOST_B = lost_bit(WIDTH, TS_WIDTH);

    cap_state_t          state;
    cap_state_t          state_nxt;
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    last;
    logic                pend_lost;
    logic                push;
    logic                push_init;
    logic                load_last;
    logic                pop;
    logic                accept;
    logic                full;
    logic                empty;
    logic [REC_W-1:0]    rec;
    logic [REC_W-1:0]    head;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_init = 1'b0;
        load_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else begin
                    push      = 1'b1;
                    push_init = 1'b1;
                    load_last = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (probe != last) begin
                    push      = 1'b1;
                    load_last = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pop    = out_valid && out_ready;
    assign accept = push && (!full || pop);
    assign rec    = {pend_lost, push_init, ts, probe};

    // last tracks the probe even when the record is dropped, so one drop is one attempt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ts        <= '0;
            last      <= '0;
            pend_lost <= 1'b0;
        end else begin
            state <= state_nxt;
            ts    <= ts + TS_WIDTH'(1);
            if (load_last) last <= probe;
            if (accept)    pend_lost <= 1'b0;
            else if (push) pend_lost <= 1'b1;
        end
    end

    capture_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (rec),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign out_valid = !empty;
    assign out_value = head[WIDTH-1:0];
    assign out_ts    = head[WIDTH +: TS_WIDTH];
    assign out_init  = head[INIT_B];
    assign out_lost  = head[LOST_B];

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - directed self-checking bench for wave_capture
module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  probe;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_ts;
    logic [7:0]  out_value;
    logic        out_init;
    logic        out_lost;
    logic [4:0]  level;

    logic        en4;
    logic [7:0]  probe4;
    logic        ready4;
    logic        valid4;
    logic [3:0]  ts4;
    logic [7:0]  value4;
    logic        init4;
    logic        lost4;
    logic [4:0]  level4;

    logic [15:0] ts_a;
    logic [15:0] ts_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    wave_capture #(.WIDTH(8), .TS_WIDTH(16), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .en(en), .probe(probe),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_value(out_value), .out_init(out_init), .out_lost(out_lost),
        .level(level)
    );

    wave_capture #(.WIDTH(8), .TS_WIDTH(4), .DEPTH(16)) dut4 (
        .clk(clk), .reset(reset), .en(en4), .probe(probe4),
        .out_valid(valid4), .out_ready(ready4), .out_ts(ts4),
        .out_value(value4), .out_init(init4), .out_lost(lost4),
        .level(level4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; probe = 8'h00; out_ready = 1'b0;
        en4 = 1'b0; probe4 = 8'h00; ready4 = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ts", 32'(out_ts), 0);
        chk("rst_value", 32'(out_value), 0);
        chk("rst_init", 32'(out_init), 0);
        chk("rst_lost", 32'(out_lost), 0);

        // Arming: first edge after release samples ts=0, arm at ts=1, init at ts=2
        reset = 1'b0;
        tick();
        en = 1'b1; probe = 8'h3C; out_ready = 1'b1;
        tick();
        chk("arm_no_valid", 32'(out_valid), 0);
        tick();
        chk("init_valid", 32'(out_valid), 1);
        chk("init_flag", 32'(out_init), 1);
        chk("init_value", 32'(out_value), 32'h3C);
        chk("init_ts", 32'(out_ts), 2);
        chk("init_lost", 32'(out_lost), 0);
        repeat (3) tick();
        chk("single_rec_valid", 32'(out_valid), 0);
        chk("single_rec_level", 32'(level), 0);

        // Change records 0x00 -> 0x01 -> 0x01 -> 0xFF
        out_ready = 1'b0;
        probe = 8'h00; tick();
        probe = 8'h01; tick();
        tick();
        probe = 8'hFF; tick();
        chk("chg_level", 32'(level), 3);
        chk("chg_head00", 32'(out_value), 32'h00);
        out_ready = 1'b1;
        tick();
        chk("chg_val01", 32'(out_value), 32'h01);
        chk("chg_init01", 32'(out_init), 0);
        ts_a = out_ts;
        tick();
        chk("chg_valFF", 32'(out_value), 32'hFF);
        ts_b = out_ts;
        chk("chg_ts_diff", 32'(16'(ts_b - ts_a)), 2);
        tick();
        chk("chg_drained", 32'(out_valid), 0);

        // Overflow: init + 20 changes into 16 entries
        en = 1'b0; out_ready = 1'b0; tick();
        en = 1'b1; probe = 8'h80; repeat (2) tick();
        for (int i = 0; i < 20; i++) begin
            probe = 8'(i + 1);
            tick();
        end
        chk("ovf_level", 32'(level), 16);
        chk("ovf_head_init", 32'(out_init), 1);
        chk("ovf_head_val", 32'(out_value), 32'h80);
        out_ready = 1'b1; probe = 8'h55; tick();
        chk("ovf_pushpop_level", 32'(level), 16);
        for (int i = 1; i <= 15; i++) begin
            chk("ovf_drain_val", 32'(out_value), 32'(i));
            chk("ovf_drain_lost", 32'(out_lost), 0);
            tick();
        end
        chk("ovf_lost_val", 32'(out_value), 32'h55);
        chk("ovf_lost_flag", 32'(out_lost), 1);
        tick();
        chk("ovf_drained", 32'(out_valid), 0);

        // Full with simultaneous push and pop, no prior drop
        en = 1'b0; out_ready = 1'b0; tick();
        en = 1'b1; probe = 8'h80; repeat (2) tick();
        for (int i = 1; i <= 15; i++) begin
            probe = 8'(i);
            tick();
        end
        chk("full_level", 32'(level), 16);
        out_ready = 1'b1; probe = 8'h66; tick();
        chk("full_pp_level", 32'(level), 16);
        chk("full_pp_head", 32'(out_value), 32'h01);
        repeat (15) tick();
        chk("full_pp_val", 32'(out_value), 32'h66);
        chk("full_pp_lost", 32'(out_lost), 0);
        chk("full_pp_init", 32'(out_init), 0);
        tick();
        chk("full_drained", 32'(out_valid), 0);

        // Asynchronous reset mid-drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            probe = 8'hA0 + 8'(i);
            tick();
        end
        chk("mid_level5", 32'(level), 5);
        out_ready = 1'b1; tick();
        chk("mid_level4", 32'(level), 4);
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_level", 32'(level), 0);
        tick();
        reset = 1'b0; en = 1'b0; en4 = 1'b0; probe4 = 8'h00; ready4 = 1'b1;
        tick();
        en = 1'b1; en4 = 1'b1; out_ready = 1'b0;
        repeat (2) tick();
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_init", 32'(out_init), 1);
        chk("post_rst_ts", 32'(out_ts), 2);
        chk("post_rst_level", 32'(level), 1);

        // 4-bit timestamp wrap: changes sampled at ts=15 and ts=0
        repeat (12) tick();
        ready4 = 1'b0; probe4 = 8'h01; tick();
        probe4 = 8'h02; tick();
        chk("wrap_level", 32'(level4), 2);
        chk("wrap_ts15", 32'(ts4), 15);
        chk("wrap_val1", 32'(value4), 1);
        ready4 = 1'b1; tick();
        chk("wrap_ts0", 32'(ts4), 0);
        chk("wrap_val2", 32'(value4), 2);
        chk("wrap_init", 32'(init4), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
# wave_capture

Hardware waveform recorder that watches a probe bus from a design under test and emits one timestamped record per value change, the in-circuit counterpart of the VCD dumper in our judge testbenches. It sits beside the DUT inside a test harness. It records an initial-value record when armed and a change record whenever the probe differs from its last recorded value. Records are buffered in an internal FIFO and drained by a consumer over a valid/ready stream.

## Interface
- `WIDTH`, 8: probe bus width.
- `TS_WIDTH`, 16: timestamp width; the counter wraps modulo 2^TS_WIDTH.
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.

- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: capture enable.
- `probe` in WIDTH: monitored signal, sampled every edge.
- `out_valid` out 1: a record is available.
- `out_ready` in 1: the consumer accepts the record.
- `out_ts` out TS_WIDTH: record timestamp.
- `out_value` out WIDTH: recorded probe value.
- `out_init` out 1: 1 = initial-value record, 0 = change record.
- `out_lost` out 1: one or more records were dropped immediately before this one.
- `level` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Timestamp counter `ts` is free-running from reset and increments every cycle regardless of `en`. It wraps from 2^TS_WIDTH−1 to 0.
- FSM states:
  - IDLE: no capture. If `en`=1, go to ARMED.
  - ARMED: push an init record {ts, probe, init=1}, load `last` with probe, then go to RUN. If `en`=0, return to IDLE and push nothing.
  - RUN: if `en`=0, go to IDLE. Otherwise, if probe != last, push a change record {ts, probe, init=0} and set `last` to probe.
- Re-enabling after IDLE always produces a fresh init record.
- FIFO is first-word-fall-through:
  - `out_*` present the head entry whenever `out_valid`=1.
  - A pop occurs on an edge with `out_valid && out_ready`.
- Full handling:
  - A push is accepted if the FIFO is not full, or if a pop happens on the same edge.
  - Otherwise the record is dropped and sticky `pend_lost` is set. `last` still updates, so the drop does not cause repeated attempts.
  - The next accepted push carries lost=1 and clears `pend_lost`.
- Simultaneous push and pop on a non-empty FIFO leaves `level` unchanged, and the order of records is preserved.
- On an empty FIFO, push and pop cannot occur on the same edge, because `out_valid`=0.
- `out_ready` with `out_valid`=0 is ignored.
- FIFO contents persist across `en` toggles. Only `reset` clears them.

## Timing
- Reset values:
  - state IDLE, ts=0, last=0, pend_lost=0, FIFO empty.
  - Outputs: `out_valid`=0, `level`=0, `out_ts`=0, `out_value`=0, `out_init`=0, `out_lost`=0.
- Reset is asynchronous. Asserting it mid-operation discards all stored and pending records immediately.
- Arming latency:
  - `en` rises before edge E: state is ARMED after E.
  - Init record is pushed at E+1 with ts = the value of ts at E+1 (sampled before the increment).
  - `out_valid` is 1 after E+1.
- Change latency: probe changes before edge C while in RUN → record pushed at C with ts(C), and `out_valid` is visible after C. This is a 1-cycle latency.
- A change at the same edge as the ARMED→RUN transition is captured in the init record, not as a separate change.
- `en` falling before edge F: changes sampled at F are not recorded.
- `out_*` and `level` are registered outputs; no combinational path from `out_ready` to them.

## Structure
- Package `wave_capture_pkg` holds:
  - the FSM state encoding (IDLE=0, ARMED=1, RUN=2);
  - the record field layout {lost, init, ts, value} and its total width, as a function of WIDTH and TS_WIDTH.
- Sub-module `capture_fifo`: a synchronous FWFT FIFO with parameters DATA_W and DEPTH, ports push/pop/full/empty/level. It is the natural split.
- FSM, timestamp counter and lost tracking live in the top module.

## Test plan
- Reset, then `en`=1 with probe=0x3C held, `out_ready`=1 → exactly one record {init=1, value=0x3C, ts=2 relative to reset release}, then no further records.
- In RUN, drive probe 0x00→0x01→0x01→0xFF on consecutive cycles → two change records, values 0x01 then 0xFF, timestamps differing by 2.
- `out_ready`=0, DEPTH=16, 20 distinct probe changes:
  - `level` saturates at 16;
  - raise `out_ready` and apply one more change;
  - drained records: init + 15 changes, then a record with lost=1 and the newest value.
- FIFO full with push and pop on the same edge → push accepted, `level` stays 16, out_lost=0.
- TS_WIDTH=4: a change at ts=15 and a change at ts=0 (after the wrap) → records with out_ts 15 then 0.
- Assert `reset` mid-drain with 5 records stored → `out_valid`=0 and `level`=0 immediately, before the next clock edge. After release and `en`=1, the first record is an init record.
